// File: rtl/square_game_pkg.sv
// Shared types and constants for the square game round sequencer and its pixel scanner.
package square_game_pkg;

    localparam int unsigned COORD_W = 11;

    localparam logic COLOR_ERASE = 1'b0;
    localparam logic COLOR_DRAW  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitLoc,
        StErase,
        StDraw,
        StHold
    } round_state_t;

endpackage

// File: rtl/square_scanner.sv
// Walks a SQ_SIZE x SQ_SIZE square in row-major order and presents one pixel per step on a
// valid/ready write port; off-screen pixels burn one cycle with valid low.
module square_scanner
    import square_game_pkg::*;
#(
    parameter int unsigned SQ_SIZE = 20,
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_i,
    input  logic [COORD_W-1:0] base_x_i,
    input  logic [COORD_W-1:0] base_y_i,
    input  logic               color_i,
    output logic               pix_valid_o,
    input  logic               pix_ready_i,
    output logic [COORD_W-1:0] pix_x_o,
    output logic [COORD_W-1:0] pix_y_o,
    output logic               pix_color_o,
    output logic               done_o
);

    localparam int unsigned OffW = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1;
    localparam logic [OffW-1:0] OffLast = OffW'(SQ_SIZE - 1);

    logic               active_q, active_d;
    logic [OffW-1:0]    off_x_q, off_x_d;
    logic [OffW-1:0]    off_y_q, off_y_d;
    logic [COORD_W-1:0] base_x_q, base_x_d;
    logic [COORD_W-1:0] base_y_q, base_y_d;
    logic               valid_q, valid_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               color_q, color_d;

    logic               advance;
    logic               last;
    logic               load;
    logic [COORD_W-1:0] cand_x;
    logic [COORD_W-1:0] cand_y;

    always_comb begin
        active_d = active_q;
        off_x_d  = off_x_q;
        off_y_d  = off_y_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        valid_d  = valid_q;
        x_d      = x_q;
        y_d      = y_q;
        color_d  = color_q;
        load     = 1'b0;

        // A skipped (clipped) pixel advances without waiting for the writer.
        advance = active_q && (!valid_q || pix_ready_i);
        last    = (off_x_q == OffLast) && (off_y_q == OffLast);
        done_o  = advance && last;

        if (start_i) begin
            active_d = 1'b1;
            base_x_d = base_x_i;
            base_y_d = base_y_i;
            color_d  = color_i;
            off_x_d  = '0;
            off_y_d  = '0;
            load     = 1'b1;
        end else if (advance) begin
            if (last) begin
                active_d = 1'b0;
                valid_d  = 1'b0;
                off_x_d  = '0;
                off_y_d  = '0;
            end else begin
                load = 1'b1;
                if (off_x_q == OffLast) begin
                    off_x_d = '0;
                    off_y_d = off_y_q + OffW'(1);
                end else begin
                    off_x_d = off_x_q + OffW'(1);
                end
            end
        end

        cand_x = base_x_d + COORD_W'(off_x_d);
        cand_y = base_y_d + COORD_W'(off_y_d);
        if (load) begin
            x_d     = cand_x;
            y_d     = cand_y;
            valid_d = (32'(cand_x) < H_RES) && (32'(cand_y) < V_RES);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            off_x_q  <= '0;
            off_y_q  <= '0;
            base_x_q <= '0;
            base_y_q <= '0;
            valid_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= 1'b0;
        end else begin
            active_q <= active_d;
            off_x_q  <= off_x_d;
            off_y_q  <= off_y_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            valid_q  <= valid_d;
            x_q      <= x_d;
            y_q      <= y_d;
            color_q  <= color_d;
        end
    end

    assign pix_valid_o = valid_q;
    assign pix_x_o     = x_q;
    assign pix_y_o     = y_q;
    assign pix_color_o = color_q;

endmodule

// File: rtl/square_round_ctrl.sv
// Round sequencer: pick a location, erase the old square, draw the new one, then hold it
// until a hit or timeout while keeping a saturating score.
module square_round_ctrl
    import square_game_pkg::*;
#(
    parameter int unsigned SQ_SIZE     = 20,
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               hit,
    output logic               pick_start,
    input  logic               pick_done,
    input  logic [COORD_W-1:0] pick_x,
    input  logic [COORD_W-1:0] pick_y,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_color,
    output logic [COORD_W-1:0] sq_x,
    output logic [COORD_W-1:0] sq_y,
    output logic               busy,
    output logic [SCORE_W-1:0] score
);

    localparam int unsigned TimerW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerLoad = TimerW'(HOLD_CYCLES - 1);

    round_state_t state_q, state_d;

    logic [COORD_W-1:0] new_x_q, new_x_d;
    logic [COORD_W-1:0] new_y_q, new_y_d;
    logic [COORD_W-1:0] sq_x_q, sq_x_d;
    logic [COORD_W-1:0] sq_y_q, sq_y_d;
    logic               drawn_q, drawn_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [SCORE_W-1:0] score_q, score_d;

    logic               scan_start;
    logic [COORD_W-1:0] scan_bx;
    logic [COORD_W-1:0] scan_by;
    logic               scan_color;
    logic               scan_done;
    logic               hold_exit;

    assign hold_exit = hit || (timer_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (enable) state_d = StReq;
            StReq:     state_d = StWaitLoc;
            StWaitLoc: if (pick_done) state_d = drawn_q ? StErase : StDraw;
            StErase:   if (scan_done) state_d = StDraw;
            StDraw:    if (scan_done) state_d = StHold;
            StHold:    if (hold_exit) state_d = enable ? StReq : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Scan base is chosen so each scan latches the right corner on its start cycle.
    always_comb begin
        pick_start = 1'b0;
        busy       = 1'b1;
        scan_start = 1'b0;
        scan_bx    = sq_x_q;
        scan_by    = sq_y_q;
        scan_color = COLOR_ERASE;
        unique case (state_q)
            StIdle: busy = 1'b0;
            StReq:  pick_start = 1'b1;
            StWaitLoc: begin
                if (pick_done) begin
                    scan_start = 1'b1;
                    if (!drawn_q) begin
                        scan_bx    = pick_x;
                        scan_by    = pick_y;
                        scan_color = COLOR_DRAW;
                    end
                end
            end
            StErase: begin
                if (scan_done) begin
                    scan_start = 1'b1;
                    scan_bx    = new_x_q;
                    scan_by    = new_y_q;
                    scan_color = COLOR_DRAW;
                end
            end
            StHold:  busy = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        new_x_d = new_x_q;
        new_y_d = new_y_q;
        sq_x_d  = sq_x_q;
        sq_y_d  = sq_y_q;
        drawn_d = drawn_q;
        timer_d = timer_q;
        score_d = score_q;
        unique case (state_q)
            StWaitLoc: begin
                if (pick_done) begin
                    new_x_d = pick_x;
                    new_y_d = pick_y;
                    if (!drawn_q) begin
                        sq_x_d = pick_x;
                        sq_y_d = pick_y;
                    end
                end
            end
            StErase: begin
                if (scan_done) begin
                    sq_x_d = new_x_q;
                    sq_y_d = new_y_q;
                end
            end
            StDraw: begin
                if (scan_done) begin
                    drawn_d = 1'b1;
                    timer_d = TimerLoad;
                end
            end
            StHold: begin
                if (timer_q != '0) timer_d = timer_q - TimerW'(1);
                if (hit && (score_q != '1)) score_d = score_q + SCORE_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            new_x_q <= '0;
            new_y_q <= '0;
            sq_x_q  <= '0;
            sq_y_q  <= '0;
            drawn_q <= 1'b0;
            timer_q <= '0;
            score_q <= '0;
        end else begin
            new_x_q <= new_x_d;
            new_y_q <= new_y_d;
            sq_x_q  <= sq_x_d;
            sq_y_q  <= sq_y_d;
            drawn_q <= drawn_d;
            timer_q <= timer_d;
            score_q <= score_d;
        end
    end

    square_scanner #(
        .SQ_SIZE (SQ_SIZE),
        .H_RES   (H_RES),
        .V_RES   (V_RES)
    ) u_scanner (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (scan_start),
        .base_x_i    (scan_bx),
        .base_y_i    (scan_by),
        .color_i     (scan_color),
        .pix_valid_o (pix_valid),
        .pix_ready_i (pix_ready),
        .pix_x_o     (pix_x),
        .pix_y_o     (pix_y),
        .pix_color_o (pix_color),
        .done_o      (scan_done)
    );

    assign sq_x  = sq_x_q;
    assign sq_y  = sq_y_q;
    assign score = score_q;

endmodule

// File: tb/tb_square_round_ctrl.sv
// Directed and randomized rounds against a pixel-list reference model of the square game.
module tb_square_round_ctrl;

    localparam int unsigned SQ   = 4;
    localparam int unsigned HOLD = 10;

    logic        clk = 1'b0;
    logic        reset_n, enable, hit, pick_done, pix_ready;
    logic [10:0] pick_x, pick_y;

    logic        pick_start, pix_valid, pix_color, busy;
    logic [10:0] pix_x, pix_y, sq_x, sq_y;
    logic [7:0]  score;

    logic        pick_start2, pix_valid2, pix_color2, busy2;
    logic [10:0] pix_x2, pix_y2, sq_x2, sq_y2;
    logic [1:0]  score2;

    square_round_ctrl #(
        .SQ_SIZE (SQ), .H_RES (640), .V_RES (480), .HOLD_CYCLES (HOLD), .SCORE_W (8)
    ) dut (
        .clk (clk), .reset_n (reset_n), .enable (enable), .hit (hit),
        .pick_start (pick_start), .pick_done (pick_done), .pick_x (pick_x), .pick_y (pick_y),
        .pix_valid (pix_valid), .pix_ready (pix_ready), .pix_x (pix_x), .pix_y (pix_y),
        .pix_color (pix_color), .sq_x (sq_x), .sq_y (sq_y), .busy (busy), .score (score)
    );

    square_round_ctrl #(
        .SQ_SIZE (SQ), .H_RES (640), .V_RES (480), .HOLD_CYCLES (HOLD), .SCORE_W (2)
    ) dut2 (
        .clk (clk), .reset_n (reset_n), .enable (enable), .hit (hit),
        .pick_start (pick_start2), .pick_done (pick_done), .pick_x (pick_x), .pick_y (pick_y),
        .pix_valid (pix_valid2), .pix_ready (pix_ready), .pix_x (pix_x2), .pix_y (pix_y2),
        .pix_color (pix_color2), .sq_x (sq_x2), .sq_y (sq_y2), .busy (busy2), .score (score2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what should be on screen and the scores.
    bit          m_drawn;
    int          m_sq_x, m_sq_y;
    int          m_score, m_score2;
    logic [22:0] exp_q[$];
    logic [22:0] got[$];

    always @(posedge clk) begin
        if (reset_n && pix_valid && pix_ready) got.push_back({pix_color, pix_x, pix_y});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_square(input int bx, input int by, input logic c);
        for (int dy = 0; dy < int'(SQ); dy++) begin
            for (int dx = 0; dx < int'(SQ); dx++) begin
                if (bx + dx < 640 && by + dy < 480)
                    exp_q.push_back({c, 11'(bx + dx), 11'(by + dy)});
            end
        end
    endtask

    task automatic model_reset();
        m_drawn  = 0;
        m_sq_x   = 0;
        m_sq_y   = 0;
        m_score  = 0;
        m_score2 = 0;
    endtask

    // mode 0: ready always high, 1: one 5-cycle stall after 5 transfers, 2: random ready.
    task automatic do_round(input int px, input int py, input int lat, input int hit_at,
                            input int mode, input bit hit_draw, input int rst_at,
                            input bit dis_hold);
        int          cyc;
        int          stall_left;
        bit          stalled;
        int          scans;
        logic        pv, pr;
        logic [10:0] ppx, ppy;

        got.delete();
        exp_q.delete();
        cyc = 0;
        while (!pick_start && cyc < 200) begin
            step();
            cyc++;
        end
        check("pick_start_seen", 64'(pick_start), 64'd1);
        step();
        check("pick_start_one_cycle", 64'(pick_start), 64'd0);
        repeat (lat) step();
        pick_x    = 11'(px);
        pick_y    = 11'(py);
        pick_done = 1'b1;
        step();
        pick_done = 1'b0;

        scans = m_drawn ? 2 : 1;
        if (m_drawn) add_square(m_sq_x, m_sq_y, 1'b0);
        add_square(px, py, 1'b1);

        stall_left = 0;
        stalled    = 0;
        cyc        = 0;
        while (busy && cyc < 2000) begin
            if (mode == 1 && !stalled && got.size() >= 5) begin
                stalled    = 1;
                stall_left = 5;
            end
            if (mode == 2) pix_ready = ($urandom_range(0, 3) != 0);
            else           pix_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            hit = hit_draw && (cyc == 2);
            if (rst_at == cyc) begin
                reset_n = 1'b0;
                #1;
                check("async_reset_outputs",
                      {8'd0, pick_start, pix_valid, pix_x, pix_y, pix_color, sq_x, sq_y, busy,
                       score}, 64'd0);
                check("async_reset_score2", 64'(score2), 64'd0);
                model_reset();
                hit       = 1'b0;
                pix_ready = 1'b1;
                return;
            end
            pv  = pix_valid;
            pr  = pix_ready;
            ppx = pix_x;
            ppy = pix_y;
            step();
            cyc++;
            if (pv && !pr)
                check("stall_stable", {41'd0, pix_valid, pix_x, pix_y}, {41'd0, 1'b1, ppx, ppy});
        end
        hit       = 1'b0;
        pix_ready = 1'b1;
        check("scan_finished", 64'(busy), 64'd0);
        if (mode != 2)
            check("scan_cycles", 64'(cyc), 64'(scans * int'(SQ * SQ) + (mode == 1 ? 5 : 0)));
        check("xfer_count", 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check("pixel", 64'(got[i]), 64'(exp_q[i]));

        m_sq_x  = px;
        m_sq_y  = py;
        m_drawn = 1;
        check("sq_xy", {42'd0, sq_x, sq_y}, {42'd0, 11'(px), 11'(py)});
        check("score_before_hold", 64'(score), 64'(m_score));

        if (dis_hold) enable = 1'b0;
        if (hit_at >= 0) begin
            repeat (hit_at) step();
            hit = 1'b1;
            step();
            hit = 1'b0;
            if (m_score < 255) m_score++;
            if (m_score2 < 3) m_score2++;
            check("score_after_hit", 64'(score), 64'(m_score));
            check("score2_after_hit", 64'(score2), 64'(m_score2));
            check("req_after_hit", 64'(pick_start), 64'(enable));
        end else begin
            repeat (HOLD - 1) step();
            check("hold_not_early", 64'(pick_start | busy), 64'd0);
            step();
            check("hold_length", 64'(pick_start), 64'(enable));
            check("timeout_score", 64'(score), 64'(m_score));
        end
    endtask

    initial begin
        int hx;
        reset_n   = 1'b0;
        enable    = 1'b1;
        hit       = 1'b0;
        pick_done = 1'b0;
        pix_ready = 1'b1;
        pick_x    = '0;
        pick_y    = '0;
        model_reset();
        #12;
        check("reset_outputs",
              {8'd0, pick_start, pix_valid, pix_x, pix_y, pix_color, sq_x, sq_y, busy, score},
              64'd0);
        check("reset_score2", 64'(score2), 64'd0);
        step();
        reset_n = 1'b1;

        do_round(10, 20, 0, -1, 0, 0, -1, 0);
        do_round(100, 50, 2, 3, 0, 1, -1, 0);
        do_round(120, 60, 1, -1, 1, 0, -1, 0);
        do_round(638, 478, 0, 0, 0, 0, -1, 0);
        do_round(300, 200, 1, -1, 0, 0, 20, 0);
        step();
        reset_n = 1'b1;
        do_round(50, 60, 0, 2, 0, 0, -1, 0);
        do_round(200, 100, 1, -1, 0, 0, -1, 1);
        repeat (3) step();
        check("idle_square_kept", {41'd0, busy, pick_start, sq_x, sq_y},
              {41'd0, 1'b0, 1'b0, 11'(m_sq_x), 11'(m_sq_y)});
        enable = 1'b1;

        for (int k = 0; k < 8; k++) begin
            if (k < 4) hx = int'($urandom_range(0, HOLD - 1));
            else       hx = int'($urandom_range(0, HOLD)) - 1;
            do_round(int'($urandom_range(0, 660)), int'($urandom_range(0, 500)),
                     int'($urandom_range(0, 3)), hx, 2, 0, -1, 0);
        end

        check("final_score", 64'(score), 64'(m_score));
        check("final_score2_saturated", 64'(score2), 64'(m_score2));
        check("dut2_square", {42'd0, sq_x2, sq_y2}, {42'd0, 11'(m_sq_x), 11'(m_sq_y)});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
